// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for a single-outstanding,
// variable-latency instruction memory port.
//
// Owns the fetch PC, issues one read per instruction, captures the returned
// word and holds it for decode while the hazard unit stalls. Redirects
// (branch/jump/jr) replace the PC at any time. A response that was already in
// flight when a redirect arrived is stale: it is waited for and dropped before
// the new target is requested.
//
// State summary:
//   ISSUE   - request pc this cycle (suppressed by a same-cycle redirect)
//   WAIT    - request outstanding, response still wanted
//   DISCARD - request outstanding, response is stale and will be dropped
//   HOLD    - instr/pc_plus_4 hold a live instruction for decode
//
// A watchdog counts response-free cycles in WAIT/DISCARD. When the count
// reaches TIMEOUT, the sticky fetch_err flag is raised, and the block keeps
// waiting for the response.

module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_addr,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic [31:0] instr,
   output logic [31:0] pc_plus_4,
   output logic        instr_valid,
   output logic        busy,
   output logic        fetch_err
);

   typedef enum logic [1:0] {
      ST_ISSUE   = 2'd0,
      ST_WAIT    = 2'd1,
      ST_DISCARD = 2'd2,
      ST_HOLD    = 2'd3
   } state_e;

   // The timeout range 1..255 fits in 8 bits.
   localparam logic [7:0]  TIMEOUT_C  = 8'(TIMEOUT);
   localparam logic [31:0] RESET_PC_A = {RESET_PC[31:2], 2'b00};

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_plus_4_q, pc_plus_4_d;
   logic        instr_valid_q, instr_valid_d;
   logic        fetch_err_q, fetch_err_d;
   logic [7:0]  miss_cnt_q, miss_cnt_d;

   logic [31:0] redirect_tgt;
   logic [31:0] pc_inc;
   logic        outstanding;
   logic        miss;
   logic [7:0]  miss_cnt_sat;

   // Word-aligned redirect target. The low address bits are dropped on purpose.
   assign redirect_tgt = {redirect_addr[31:2], 2'b00};

   // The dropped low bits are consumed here so that lint sees them as used.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^redirect_addr[1:0];

   // Sequential addition wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
   assign pc_inc = pc_q + 32'd4;

   // A read is in flight exactly in WAIT and DISCARD.
   assign outstanding  = (state_q == ST_WAIT) || (state_q == ST_DISCARD);
   assign miss         = outstanding && !mem_rvalid;
   assign miss_cnt_sat = (miss_cnt_q == TIMEOUT_C) ? miss_cnt_q : miss_cnt_q + 8'd1;

   // Next-state, PC and capture logic for the fetch FSM.
   always_comb begin
      // NOTE: every signal assigned in this block gets a default first. Without
      // the defaults, a path through the case that skips an assignment would
      // infer a latch.
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      pc_plus_4_d   = pc_plus_4_q;
      instr_valid_d = instr_valid_q;
      fetch_err_d   = fetch_err_q;
      miss_cnt_d    = miss_cnt_q;

      unique case (state_q)
         ST_ISSUE: begin
            if (redirect) begin
               pc_d = redirect_tgt;
            end else begin
               miss_cnt_d = '0;
               state_d    = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (mem_rvalid) begin
               if (redirect) begin
                  // The returned word belongs to the old path. Drop it.
                  pc_d    = redirect_tgt;
                  state_d = ST_ISSUE;
               end else begin
                  instr_d       = mem_rdata;
                  pc_plus_4_d   = pc_inc;
                  instr_valid_d = 1'b1;
                  state_d       = ST_HOLD;
               end
            end else if (redirect) begin
               pc_d    = redirect_tgt;
               state_d = ST_DISCARD;
            end
         end

         ST_DISCARD: begin
            // The latest redirect wins, even in the cycle the stale data arrives.
            if (redirect) begin
               pc_d = redirect_tgt;
            end
            if (mem_rvalid) begin
               state_d = ST_ISSUE;
            end
         end

         ST_HOLD: begin
            // A redirect takes priority over stall.
            if (redirect) begin
               pc_d          = redirect_tgt;
               instr_valid_d = 1'b0;
               state_d       = ST_ISSUE;
            end else if (!stall) begin
               pc_d          = pc_inc;
               instr_valid_d = 1'b0;
               state_d       = ST_ISSUE;
            end
         end

         default: begin
            state_d = ST_ISSUE;
         end
      endcase

      // Watchdog: count response-free cycles, saturating at TIMEOUT.
      if (miss) begin
         miss_cnt_d = miss_cnt_sat;
         if (miss_cnt_sat == TIMEOUT_C) begin
            fetch_err_d = 1'b1;
         end
      end
   end

   // State register with synchronous active-high reset.
   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignments so that every flop
      // samples the pre-edge values, whatever the statement order.
      if (reset) begin
         state_q       <= ST_ISSUE;
         pc_q          <= RESET_PC_A;
         instr_q       <= '0;
         pc_plus_4_q   <= '0;
         instr_valid_q <= 1'b0;
         fetch_err_q   <= 1'b0;
         miss_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         pc_plus_4_q   <= pc_plus_4_d;
         instr_valid_q <= instr_valid_d;
         fetch_err_q   <= fetch_err_d;
         miss_cnt_q    <= miss_cnt_d;
      end
   end

   // The request strobe is combinational so that a same-cycle redirect can
   // suppress a request to the stale pc.
   assign mem_req     = (state_q == ST_ISSUE) && !redirect;
   assign mem_addr    = pc_q;
   assign busy        = (state_q != ST_HOLD);
   assign instr       = instr_q;
   assign pc_plus_4   = pc_plus_4_q;
   assign instr_valid = instr_valid_q;
   assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl.
// A directed vector table covers the basic 3-cycle fetch and a discard after
// a redirect. Hand-written sequences cover stall hold, redirect with stall, PC
// wrap, timeout and reset in WAIT. A randomized phase compares every cycle
// against a transaction-level reference model, with a memory responder that
// has random latency.

module tb_fetch_ctrl;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int unsigned TIMEOUT  = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_addr = '0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata = '0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] instr;
   logic [31:0] pc_plus_4;
   logic        instr_valid;
   logic        busy;
   logic        fetch_err;

   always #5 clk = ~clk;

   fetch_ctrl #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
      .redirect_addr(redirect_addr), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .instr(instr),
      .pc_plus_4(pc_plus_4), .instr_valid(instr_valid), .busy(busy),
      .fetch_err(fetch_err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- memory responder ----------------
   int          cyc = 0;
   bit          mem_pend = 0;
   int          mem_due = 0;
   logic [31:0] mem_word = '0;
   int          lat_lo = 1, lat_hi = 1;
   int          word_mode = 0;   // 0: addr^A5A5_0000, 1: 0x2402_0005, 2: random
   bit          spur_en = 0;

   function automatic logic [31:0] word_for(input logic [31:0] a);
      case (word_mode)
         0:       return a ^ 32'hA5A5_0000;
         1:       return 32'h2402_0005;
         default: return $urandom;
      endcase
   endfunction

   // ---------------- reference model ----------------
   // The model tracks what is in flight, whether the in-flight response is
   // still wanted, and whether decode holds an instruction.
   bit          m_ok = 0;
   logic [31:0] m_pc, m_instr, m_pp4;
   bit          m_out, m_stale, m_have, m_err;
   int          m_miss;

   task automatic model_step(input bit rst, input bit st, input bit rd,
                             input logic [31:0] ra, input bit rv, input logic [31:0] rdw);
      logic [31:0] tgt;
      tgt = ra & 32'hFFFF_FFFC;
      if (rst) begin
         m_pc = RESET_PC; m_out = 0; m_stale = 0; m_have = 0;
         m_instr = '0; m_pp4 = '0; m_err = 0; m_miss = 0; m_ok = 1;
      end else if (m_have) begin
         if (rd)       begin m_pc = tgt;       m_have = 0; end
         else if (!st) begin m_pc = m_pc + 4;  m_have = 0; end
      end else if (!m_out) begin
         if (rd) m_pc = tgt;
         else begin m_out = 1; m_stale = 0; m_miss = 0; end
      end else begin
         if (rv) begin
            m_out = 0;
            if (!m_stale && !rd) begin
               m_instr = rdw; m_pp4 = m_pc + 4; m_have = 1;
            end
         end else begin
            m_stale = m_stale | rd;
            if (m_miss < TIMEOUT) m_miss++;
            if (m_miss == TIMEOUT) m_err = 1;
         end
         if (rd) m_pc = tgt;
      end
   endtask

   // One clock cycle. It is entered just after a falling edge and returns at
   // the next falling edge.
   task automatic tick(input bit rst, input bit st, input bit rd, input logic [31:0] ra);
      bit          rv;
      logic [31:0] rdw;
      if (m_ok) begin
         check("m_valid", instr_valid, m_have);
         check("m_instr", instr, m_instr);
         check("m_pp4", pc_plus_4, m_pp4);
         check("m_err", fetch_err, m_err);
      end
      rv  = 0;
      rdw = $urandom;
      if (mem_pend && cyc == mem_due) begin
         rv = 1; rdw = mem_word;
      end else if (spur_en && !mem_pend && $urandom_range(7) == 0) begin
         rv = 1;
      end
      reset = rst; stall = st; redirect = rd; redirect_addr = ra;
      mem_rvalid = rv; mem_rdata = rdw;
      #1;
      if (m_ok) begin
         check("m_req", mem_req, (!m_out && !m_have && !rd));
         check("m_addr", mem_addr, m_pc);
         check("m_busy", busy, !m_have);
      end
      if (rv && mem_pend) mem_pend = 0;
      if (mem_req === 1'b1 && !rst) begin
         mem_pend = 1;
         mem_due  = cyc + $urandom_range(lat_hi, lat_lo);
         mem_word = word_for(mem_addr);
      end
      if (rst) mem_pend = 0;
      model_step(rst, st, rd, ra, rv, rdw);
      @(negedge clk);
      cyc++;
   endtask

   task automatic drive_idle();
      reset = 0; stall = 0; redirect = 0; mem_rvalid = 0;
      #1;
   endtask

   task automatic wait_valid(input string name, input int budget);
      int n;
      n = 0;
      while (instr_valid !== 1'b1 && n < budget) begin
         tick(0, 0, 0, '0);
         n++;
      end
      check(name, instr_valid, 1'b1);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit chk; bit rst; bit st; bit rd; logic [31:0] ra; bit rv; logic [31:0] rdw;
      bit e_req; logic [31:0] e_addr; bit e_busy; bit e_valid;
      logic [31:0] e_instr; logic [31:0] e_pp4;
   } vec_t;

   localparam int NV = 22;
   vec_t tbl[NV];

   function automatic vec_t v(bit chk, bit rst, bit st, bit rd, logic [31:0] ra, bit rv,
                              logic [31:0] rdw, bit req, logic [31:0] addr, bit bsy,
                              bit vld, logic [31:0] ins, logic [31:0] pp4);
      vec_t r;
      r.chk = chk; r.rst = rst; r.st = st; r.rd = rd; r.ra = ra; r.rv = rv; r.rdw = rdw;
      r.e_req = req; r.e_addr = addr; r.e_busy = bsy; r.e_valid = vld;
      r.e_instr = ins; r.e_pp4 = pp4;
      return r;
   endfunction

   initial begin
      // Rows give the inputs for one cycle and the outputs expected in that
      // cycle. Registered outputs show the result of the earlier rows.
      //            chk rst st rd ra           rv rdw             req addr          bsy vld instr           pp4
      tbl[0]  = v(0,  1, 0, 0, 32'h0,       0, 32'h0,          0, 32'h0,        0, 0, 32'h0,          32'h0);
      tbl[1]  = v(1,  0, 0, 0, 32'h0,       0, 32'h0,          1, 32'h0,        1, 0, 32'h0,          32'h0);
      tbl[2]  = v(1,  0, 0, 0, 32'h0,       1, 32'hA5A5_0000,  0, 32'h0,        1, 0, 32'h0,          32'h0);
      tbl[3]  = v(1,  0, 0, 0, 32'h0,       0, 32'h0,          0, 32'h0,        0, 1, 32'hA5A5_0000,  32'h4);
      tbl[4]  = v(1,  0, 0, 0, 32'h0,       0, 32'h0,          1, 32'h4,        1, 0, 32'hA5A5_0000,  32'h4);
      tbl[5]  = v(1,  0, 0, 0, 32'h0,       1, 32'hA5A5_0004,  0, 32'h4,        1, 0, 32'hA5A5_0000,  32'h4);
      tbl[6]  = v(1,  0, 0, 0, 32'h0,       0, 32'h0,          0, 32'h4,        0, 1, 32'hA5A5_0004,  32'h8);
      tbl[7]  = v(1,  0, 0, 0, 32'h0,       0, 32'h0,          1, 32'h8,        1, 0, 32'hA5A5_0004,  32'h8);
      tbl[8]  = v(1,  0, 0, 0, 32'h0,       1, 32'hA5A5_0008,  0, 32'h8,        1, 0, 32'hA5A5_0004,  32'h8);
      tbl[9]  = v(1,  0, 0, 0, 32'h0,       0, 32'h0,          0, 32'h8,        0, 1, 32'hA5A5_0008,  32'hC);
      tbl[10] = v(1,  0, 0, 0, 32'h0,       0, 32'h0,          1, 32'hC,        1, 0, 32'hA5A5_0008,  32'hC);
      tbl[11] = v(1,  0, 0, 1, 32'h103,     0, 32'h0,          0, 32'hC,        1, 0, 32'hA5A5_0008,  32'hC);
      tbl[12] = v(1,  0, 0, 0, 32'h0,       0, 32'h0,          0, 32'h100,      1, 0, 32'hA5A5_0008,  32'hC);
      tbl[13] = v(1,  0, 0, 0, 32'h0,       0, 32'h0,          0, 32'h100,      1, 0, 32'hA5A5_0008,  32'hC);
      tbl[14] = v(1,  0, 0, 0, 32'h0,       1, 32'hDEAD_BEEF,  0, 32'h100,      1, 0, 32'hA5A5_0008,  32'hC);
      tbl[15] = v(1,  0, 0, 0, 32'h0,       0, 32'h0,          1, 32'h100,      1, 0, 32'hA5A5_0008,  32'hC);
      tbl[16] = v(1,  0, 0, 0, 32'h0,       0, 32'h0,          0, 32'h100,      1, 0, 32'hA5A5_0008,  32'hC);
      tbl[17] = v(1,  0, 0, 0, 32'h0,       0, 32'h0,          0, 32'h100,      1, 0, 32'hA5A5_0008,  32'hC);
      tbl[18] = v(1,  0, 0, 0, 32'h0,       0, 32'h0,          0, 32'h100,      1, 0, 32'hA5A5_0008,  32'hC);
      tbl[19] = v(1,  0, 0, 0, 32'h0,       1, 32'h1234_5678,  0, 32'h100,      1, 0, 32'hA5A5_0008,  32'hC);
      tbl[20] = v(1,  0, 1, 0, 32'h0,       0, 32'h0,          0, 32'h100,      0, 1, 32'h1234_5678,  32'h104);
      tbl[21] = v(1,  0, 1, 0, 32'h0,       0, 32'h0,          0, 32'h100,      0, 1, 32'h1234_5678,  32'h104);

      @(negedge clk);

      // ---- table: 3-cycle fetch, then a redirect during WAIT that discards ----
      for (int i = 0; i < NV; i++) begin
         if (tbl[i].chk) begin
            check($sformatf("tbl%0d_valid", i), instr_valid, tbl[i].e_valid);
            check($sformatf("tbl%0d_instr", i), instr, tbl[i].e_instr);
            check($sformatf("tbl%0d_pp4", i), pc_plus_4, tbl[i].e_pp4);
            check($sformatf("tbl%0d_err", i), fetch_err, 1'b0);
         end
         reset = tbl[i].rst; stall = tbl[i].st; redirect = tbl[i].rd;
         redirect_addr = tbl[i].ra; mem_rvalid = tbl[i].rv; mem_rdata = tbl[i].rdw;
         #1;
         if (tbl[i].chk) begin
            check($sformatf("tbl%0d_req", i), mem_req, tbl[i].e_req);
            check($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].e_addr);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
         end
         @(negedge clk);
      end

      // ---- stall hold with 4-cycle latency ----
      lat_lo = 4; lat_hi = 4; word_mode = 1;
      tick(1, 0, 0, '0);
      wait_valid("p2_first_valid", 20);
      for (int k = 0; k < 5; k++) begin
         check("p2_hold_instr", instr, 32'h2402_0005);
         check("p2_hold_pp4", pc_plus_4, 32'h4);
         check("p2_hold_busy", busy, 1'b0);
         tick(0, 1, 0, '0);
      end
      tick(0, 0, 0, '0);
      check("p2_next_req", mem_req, 1'b1);
      check("p2_next_addr", mem_addr, 32'h4);

      // ---- redirect with stall in HOLD, then pc wrap ----
      lat_lo = 1; lat_hi = 1;
      wait_valid("p4_valid", 20);
      tick(0, 1, 1, 32'h0000_0200);
      drive_idle();
      check("p4_valid_drop", instr_valid, 1'b0);
      check("p4_req", mem_req, 1'b1);
      check("p4_addr", mem_addr, 32'h0000_0200);
      tick(0, 0, 1, 32'hFFFF_FFFF);
      drive_idle();
      check("p4_wrap_addr", mem_addr, 32'hFFFF_FFFC);
      wait_valid("p4_wrap_valid", 20);
      check("p4_wrap_pp4", pc_plus_4, 32'h0000_0000);
      tick(0, 0, 0, '0);
      check("p4_wrap_req", mem_req, 1'b1);
      check("p4_wrap_next", mem_addr, 32'h0000_0000);

      // ---- timeout ----
      lat_lo = 1000; lat_hi = 1000;
      tick(1, 0, 0, '0);
      tick(0, 0, 0, '0);                 // ISSUE -> WAIT
      for (int k = 1; k <= 16; k++) begin
         tick(0, 0, 0, '0);
         if (k == 15) check("p5_err_early", fetch_err, 1'b0);
         if (k == 16) begin
            check("p5_err_set", fetch_err, 1'b1);
            check("p5_busy", busy, 1'b1);
         end
      end
      for (int k = 0; k < 3; k++) tick(0, 0, 0, '0);
      mem_due = cyc;                     // late response arrives now
      tick(0, 0, 0, '0);
      check("p5_late_valid", instr_valid, 1'b1);
      check("p5_late_instr", instr, 32'h2402_0005);
      check("p5_err_sticky", fetch_err, 1'b1);
      tick(1, 0, 0, '0);
      check("p5_err_clear", fetch_err, 1'b0);

      // ---- reset while in WAIT ----
      lat_lo = 4; lat_hi = 4; word_mode = 0;
      wait_valid("p6_valid", 20);
      check("p6_instr_before", instr, 32'hA5A5_0000);
      tick(0, 0, 0, '0);                 // HOLD -> ISSUE
      tick(0, 0, 0, '0);                 // ISSUE -> WAIT
      tick(0, 0, 0, '0);                 // in WAIT
      tick(1, 0, 0, '0);                 // reset in WAIT
      drive_idle();
      check("p6_instr", instr, 32'h0);
      check("p6_valid", instr_valid, 1'b0);
      check("p6_req", mem_req, 1'b1);
      check("p6_addr", mem_addr, RESET_PC);
      check("p6_busy", busy, 1'b1);

      // ---- randomized against the reference model ----
      lat_lo = 1; lat_hi = 6; word_mode = 2; spur_en = 1;
      tick(1, 0, 0, '0);
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] ra;
         ra = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
         tick($urandom_range(199) == 0, $urandom_range(2) == 0, $urandom_range(9) == 0, ra);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time bound so that the run always ends.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
